adder_pipe: RTL and testbench

Parametrised, pipelined successor to the team's combinational 16-bit adder. It adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, and reports sum, carry-out and signed overflow. A valid/ready handshake on both sides lets the UART host interface, or any other producer, stream back-to-back operations at one per cycle with backpressure.

---
 rtl/adder_pkg.sv | 32 +++
 rtl/adder_stage.sv | 76 +++++++
 rtl/adder_pipe.sv | 148 ++++++++++++++
 tb/tb_adder_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//
// Shared definitions for the pipelined adder/subtractor:
//   - operation mode encodings driven on in_mode
//   - helpers that derive the pipeline depth from WIDTH/CHUNK and validate
//     that the operand width splits into whole slices
// ----------------------------------------------------------------------------
package adder_pkg;

    // Operation select carried on in_mode.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of CHUNK-bit slices (one pipeline stage each). Never returns 0,
    // so a degenerate configuration still elaborates far enough to report
    // the configuration error instead of failing on a zero-sized array.
    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned chunk);
        if (chunk == 0 || width < chunk) begin
            return 1;
        end
        return width / chunk;
    endfunction

    // True when WIDTH is a non-zero whole multiple of CHUNK.
    function automatic bit chunk_fits(input int unsigned width,
                                      input int unsigned chunk);
        return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage : adder_pkg

// File: rtl/adder_stage.sv
// ----------------------------------------------------------------------------
// adder_stage
//
// One registered CHUNK-bit slice of the ripple-by-stage adder. Adds two
// operand chunks plus a carry-in and registers the sum chunk and the
// carry-out when en_i is high; holds otherwise.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset, clears all registers
//   en_i     load enable (pipeline advance)
//   a_i      operand A chunk
//   b_i      operand B chunk (already inverted for subtraction)
//   cin_i    carry into this slice
//   sum_o    registered sum chunk
//   cout_o   registered carry out of this slice
//   cmsb_o   registered carry into the slice MSB (only when CaptureMsb),
//            used for signed overflow detection in the top slice
// ----------------------------------------------------------------------------
module adder_stage #(
    parameter int unsigned CHUNK      = 8,
    parameter bit          CaptureMsb = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    // One extra bit captures the carry out of the slice.
    logic [CHUNK:0]   sum_w;
    logic [CHUNK-1:0] sum_q;
    logic             cout_q;

    assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= sum_w[CHUNK-1:0];
            cout_q <= sum_w[CHUNK];
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

    if (CaptureMsb) begin : g_msb
        logic cmsb_w;
        logic cmsb_q;

        // The MSB sum bit is a ^ b ^ carry_in_to_msb, so the carry into the
        // MSB falls out of the slice sum without a second adder.
        assign cmsb_w = sum_w[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cmsb_q <= 1'b0;
            end else if (en_i) begin
                cmsb_q <= cmsb_w;
            end
        end

        assign cmsb_o = cmsb_q;
    end else begin : g_no_msb
        assign cmsb_o = 1'b0;
    end

endmodule : adder_stage

// File: rtl/adder_pipe.sv
// ----------------------------------------------------------------------------
// adder_pipe
//
// Pipelined WIDTH-bit adder/subtractor. Operands are consumed one CHUNK-bit
// slice per stage, so the critical path is a single CHUNK-bit add regardless
// of WIDTH. Streams one operation per cycle with valid/ready backpressure on
// both sides; results leave in strict arrival order.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset; drops all in-flight beats
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (= !out_valid || out_ready)
//   in_a/in_b  operands
//   in_mode    MODE_ADD (a+b) or MODE_SUB (a-b)
//   out_valid  result beat present
//   out_ready  consumer accepts the result beat
//   out_sum    result modulo 2^WIDTH
//   out_carry  carry out of a + (b ^ {WIDTH{mode}}) + mode (SUB: 1 = no borrow)
//   out_ovf    signed overflow
// ----------------------------------------------------------------------------
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_cfg_err
        $error("adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

    // ------------------------------------------------------------------------
    // Handshake: the whole pipeline moves in lockstep, so a single advance
    // signal gates every stage. This is the only in/out combinational path.
    // ------------------------------------------------------------------------
    logic adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Subtraction is a + ~b + 1; the +1 enters as the first slice carry-in.
    logic [WIDTH-1:0] bx_in;
    logic             cin0;

    assign bx_in = (in_mode == MODE_SUB) ? ~in_b : in_b;
    assign cin0  = (in_mode == MODE_SUB);

    // ------------------------------------------------------------------------
    // Per-stage state held in the top: valid chain, operands still to be
    // consumed by later slices, and result chunks already produced.
    // Stage k's slice sum/carry live inside its adder_stage instance.
    // ------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  bx_q  [STAGES];
    logic [WIDTH-1:0]  lo_q  [STAGES];
    logic [WIDTH-1:0]  res_w [STAGES];

    logic [CHUNK-1:0]  sum_w [STAGES];
    logic [STAGES-1:0] carry_w;
    logic [STAGES-1:0] cmsb_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                lo_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            a_q[0]     <= in_a;
            bx_q[0]    <= bx_in;
            // Stage 0 has no completed chunks below it.
            lo_q[0]    <= '0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                a_q[k]     <= a_q[k-1];
                bx_q[k]    <= bx_q[k-1];
                lo_q[k]    <= res_w[k-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Slice datapath
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] a_chunk;
        logic [CHUNK-1:0] b_chunk;
        logic             cin;

        if (k == 0) begin : g_first
            assign a_chunk = in_a[CHUNK-1:0];
            assign b_chunk = bx_in[CHUNK-1:0];
            assign cin     = cin0;
        end else begin : g_rest
            assign a_chunk = a_q[k-1][k*CHUNK +: CHUNK];
            assign b_chunk = bx_q[k-1][k*CHUNK +: CHUNK];
            assign cin     = carry_w[k-1];
        end

        adder_stage #(
            .CHUNK      (CHUNK),
            .CaptureMsb (k == STAGES - 1)
        ) u_stage (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (adv),
            .a_i    (a_chunk),
            .b_i    (b_chunk),
            .cin_i  (cin),
            .sum_o  (sum_w[k]),
            .cout_o (carry_w[k]),
            .cmsb_o (cmsb_w[k])
        );

        // Bits above chunk k are always zero in lo_q (they only ever come
        // from lower stages), so OR-ing in the new chunk is sufficient.
        assign res_w[k] = lo_q[k] | (WIDTH'(sum_w[k]) << (k * CHUNK));
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from the last stage registers.
    // ------------------------------------------------------------------------
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = res_w[STAGES-1];
    assign out_carry = carry_w[STAGES-1];
    assign out_ovf   = cmsb_w[STAGES-1] ^ carry_w[STAGES-1];

endmodule : adder_pipe

// File: tb/tb_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_adder_pipe
//
// Self-checking bench for adder_pipe at WIDTH=16, CHUNK=4 (4 stages).
// Directed corner cases, a full-rate random stream, a random backpressure
// phase against a scoreboard, and an asynchronous mid-flight reset.
// ----------------------------------------------------------------------------
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Expected result packed as {sum, carry, ovf}.
    logic [W+1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic mode);
        int          ua;
        int          ub;
        int          sa;
        int          sb;
        int          full;
        int          sr;
        logic        carry;
        logic        ovf;
        logic [W-1:0] sum;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (mode == MODE_SUB) begin
            full = ua - ub + 65536;
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            sr   = sa + sb;
        end
        carry = (full >= 65536);
        sum   = W'(full % 65536);
        ovf   = (sr > 32767) || (sr < -32768);
        return {sum, carry, ovf};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipeline; checks latency and spec constants.
    task automatic run_one(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic mode,
                           input logic [W-1:0] esum, input logic ec,
                           input logic eo);
        int unsigned lat;
        in_a      = a;
        in_b      = b;
        in_mode   = mode;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, S);
        check({tag, "_sum"}, 32'(out_sum), 32'(esum));
        check({tag, "_carry"}, 32'(out_carry), 32'(ec));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        step();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int unsigned sent;
        int unsigned got;
        int unsigned gaps;
        int unsigned first_cyc;
        logic        stalled;
        logic [W+2:0] held;
        logic [W+1:0] e;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = MODE_ADD;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        step();
        step();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'd0);
        check("reset_out_flags", 32'({out_carry, out_ovf}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b0;
        step();

        // ---------------- directed corners ----------------
        run_one("add_ffff_1", 16'hFFFF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0);
        run_one("add_7fff_1", 16'h7FFF, 16'h0001, MODE_ADD, 16'h8000, 1'b0, 1'b1);
        run_one("sub_8000_1", 16'h8000, 16'h0001, MODE_SUB, 16'h7FFF, 1'b1, 1'b1);
        run_one("sub_3_5", 16'h0003, 16'h0005, MODE_SUB, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_1234_1234", 16'h1234, 16'h1234, MODE_SUB, 16'h0000, 1'b1, 1'b0);

        // ---------------- full-rate stream ----------------
        out_ready = 1'b1;
        sent      = 0;
        got       = 0;
        gaps      = 0;
        first_cyc = 0;
        exp_q.delete();
        for (int unsigned cyc = 0; cyc < 100 + S + 10; cyc++) begin
            if (sent < 100) begin
                in_valid = 1'b1;
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_mode  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (got == 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("stream_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_res", 32'({out_sum, out_carry, out_ovf}), 32'(e));
                end
                got++;
            end else if (got > 0 && got < 100) begin
                gaps++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_mode));
                sent++;
            end
            step();
        end
        check("stream_count", got, 32'd100);
        check("stream_first_latency", first_cyc, S);
        check("stream_gaps", gaps, 32'd0);
        check("stream_left", exp_q.size(), 32'd0);

        // ---------------- random backpressure ----------------
        exp_q.delete();
        stalled = 1'b0;
        held    = '0;
        for (int unsigned cyc = 0; cyc < 500; cyc++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_mode   = 1'($urandom);
            #1;
            check("ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stalled) begin
                check("stall_hold", 32'({out_valid, out_sum, out_carry, out_ovf}),
                      32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bp_res", 32'({out_sum, out_carry, out_ovf}), 32'(e));
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, out_sum, out_carry, out_ovf};
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_mode));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int unsigned cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp_drain_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bp_drain_res", 32'({out_sum, out_carry, out_ovf}), 32'(e));
                end
            end
            step();
        end
        check("bp_lost", exp_q.size(), 32'd0);

        // ---------------- async reset mid-flight ----------------
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 16'h1111;
            in_b     = 16'h2222;
            in_mode  = MODE_ADD;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_sum", 32'(out_sum), 32'h3333);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_sum", 32'(out_sum), 32'd0);
        check("rst_async_flags", 32'({out_carry, out_ovf}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        step();
        for (int unsigned i = 0; i < 6; i++) begin
            check("rst_no_stale", 32'(out_valid), 32'd0);
            step();
        end
        run_one("post_rst_1_2", 16'h0001, 16'h0002, MODE_ADD, 16'h0003, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_adder_pipe
